fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch controller for the pipelined CPU. It owns the PC register and sequences the instruction-memory request handshake. It drives the PC predictor with the current PC/instruction and consumes its predicted next PC. It also handles ID-stage stalls with a one-entry skid buffer, services mispredict redirects (including draining an in-flight fetch), loads the IF/ID register, and keeps fetch/redirect statistics.

Parameters:
WORD_SIZE, 16, datapath/address width
RESET_PC, 16'h0000, PC value after reset
STAT_WIDTH, 16, width of saturating statistics counters

Ports:
clk  in  1  system clock, all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
i_readM  out  1  instruction-memory read request
i_address  out  WORD_SIZE  fetch address, equal to PC register
i_ready  in  1  memory returns i_data this cycle
i_data  in  WORD_SIZE  fetched instruction
pred_pc  out  WORD_SIZE  PC presented to predictor
pred_instr  out  WORD_SIZE  instruction presented to predictor
pred_next_pc  in  WORD_SIZE  predictor's combinational next PC
stall  in  1  ID hazard; IF/ID must hold
redirect  in  1  later stage resolved a mispredict/jump-register
redirect_pc  in  WORD_SIZE  corrected PC
if_valid  out  1  IF/ID register valid
if_instr  out  WORD_SIZE  IF/ID instruction
if_pc  out  WORD_SIZE  IF/ID PC
flush  out  1  one-cycle pulse, squash younger pipeline stages
stat_fetched  out  STAT_WIDTH  instructions delivered to IF/ID
stat_redirects  out  STAT_WIDTH  redirects accepted

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; state=IDLE.
  - if_valid=0, if_instr=0, if_pc=0, flush=0.
  - Skid buffer invalid; both stat counters=0.
  - i_readM=0 whenever state is IDLE or HOLD.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: i_readM=0; next state FETCH unconditionally.
- FETCH:
  - Drives i_readM=1, i_address=pc, pred_pc=pc, pred_instr=i_data.
  - i_ready=0 and stall=0: IF/ID loads a bubble (if_valid=0).
  - i_ready=0 and stall=1: IF/ID holds.
  - i_ready=1 and stall=0: IF/ID loads {1, i_data, pc}; pc<=pred_next_pc; stat_fetched++; stay in FETCH. Zero-wait memory gives one instruction per cycle.
  - i_ready=1 and stall=1: skid buffer captures {i_data, pc, pred_next_pc}; IF/ID holds; go to HOLD; pc unchanged.
- HOLD:
  - i_readM=0; pred_pc and pred_instr come from the buffer.
  - stall=1: remain in HOLD.
  - stall=0: IF/ID loads the buffer; pc<=buffered next PC; buffer invalid; stat_fetched++; go to FETCH.
- DRAIN:
  - Keeps i_readM=1 at the old address (memory requests must complete).
  - IF/ID loads bubbles while stall=0.
  - On i_ready, data is discarded; go to FETCH at pc.
- Redirect (priority over stall, evaluated in every state except IDLE):
  - pc<=redirect_pc; IF/ID cleared (if_valid=0) even if stall=1; skid buffer invalid.
  - flush=1 on the following cycle only.
  - stat_redirects++.
  - If in FETCH with i_ready=0: next state DRAIN. Otherwise: next state FETCH, and any same-cycle i_data is dropped.
  - Redirect during DRAIN: updates pc and stays in DRAIN.
  - Redirect in IDLE is ignored.
- Statistics saturate at all-ones and never wrap.
- PC arithmetic is WORD_SIZE bits and wraps modulo 2^WORD_SIZE; the block adds nothing beyond pred_next_pc.
- Reset asserted mid-operation discards any outstanding request. i_readM drops in the same cycle. After release, fetch starts from RESET_PC via IDLE.

Test Plan:
- Reset release, i_ready tied 1, instructions non-branch -> IDLE for 1 cycle, then i_address 0x0000,0x0001,0x0002 on consecutive cycles; if_pc follows one cycle later; stat_fetched=3 after 3 fetches.
- i_ready low for 2 cycles at 0x0000 -> i_address held 0x0000 for 3 cycles; if_valid=0 on those edges; instruction loaded on the 3rd edge.
- BEQ at 0x000F (offset +3) fetched with stall=1 for 2 cycles -> HOLD, i_readM=0, IF/ID unchanged; stall release loads if_pc=0x000F; next request i_address=0x0013.
- Redirect to 0x0040 while fetching 0x0005 with i_ready=0 -> DRAIN; i_address stays 0x0005 until i_ready; data dropped; flush pulses once; next request 0x0040; stat_redirects=1.
- Redirect and stall both high in HOLD -> if_valid=0, buffer dropped, next i_address=redirect_pc, stall ignored.
- reset_n low mid-DRAIN -> i_readM=0 immediately; all outputs at reset values; after release, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : PC owner, instruction-fetch handshake, skid buffer, stats
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int                   WORD_SIZE  = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int                   STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  i_readM,
  output logic [WORD_SIZE-1:0]  i_address,
  input  logic                  i_ready,
  input  logic [WORD_SIZE-1:0]  i_data,
  output logic [WORD_SIZE-1:0]  pred_pc,
  output logic [WORD_SIZE-1:0]  pred_instr,
  input  logic [WORD_SIZE-1:0]  pred_next_pc,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [WORD_SIZE-1:0]  redirect_pc,
  output logic                  if_valid,
  output logic [WORD_SIZE-1:0]  if_instr,
  output logic [WORD_SIZE-1:0]  if_pc,
  output logic                  flush,
  output logic [STAT_WIDTH-1:0] stat_fetched,
  output logic [STAT_WIDTH-1:0] stat_redirects
);

  localparam logic [STAT_WIDTH-1:0] c_stat_one = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t               r_state, w_next_state;
  logic [WORD_SIZE-1:0] r_pc, w_pc;
  logic [WORD_SIZE-1:0] r_drain_addr, w_drain_addr;
  logic                 r_buf_valid, w_buf_valid;
  logic [WORD_SIZE-1:0] r_buf_instr, w_buf_instr;
  logic [WORD_SIZE-1:0] r_buf_pc, w_buf_pc;
  logic [WORD_SIZE-1:0] r_buf_next, w_buf_next;
  logic                 r_if_valid, w_if_valid;
  logic [WORD_SIZE-1:0] r_if_instr, w_if_instr;
  logic [WORD_SIZE-1:0] r_if_pc, w_if_pc;
  logic                 r_flush;
  logic [STAT_WIDTH-1:0] r_stat_fetched, r_stat_redirects;
  logic                 w_redirect_taken;
  logic                 w_deliver;

  always_comb begin
    w_next_state     = r_state;
    w_pc             = r_pc;
    w_drain_addr     = r_drain_addr;
    w_buf_valid      = r_buf_valid;
    w_buf_instr      = r_buf_instr;
    w_buf_pc         = r_buf_pc;
    w_buf_next       = r_buf_next;
    w_if_valid       = r_if_valid;
    w_if_instr       = r_if_instr;
    w_if_pc          = r_if_pc;
    w_deliver        = 1'b0;
    w_redirect_taken = redirect && (r_state != S_IDLE);

    if (w_redirect_taken) begin
      // An unanswered request must still complete before fetching the new path
      w_pc        = redirect_pc;
      w_if_valid  = 1'b0;
      w_buf_valid = 1'b0;
      if ((r_state == S_FETCH || r_state == S_DRAIN) && !i_ready) begin
        w_next_state = S_DRAIN;
        if (r_state == S_FETCH) w_drain_addr = r_pc;
      end else begin
        w_next_state = S_FETCH;
      end
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_FETCH;
        S_FETCH: begin
          if (i_ready && !stall) begin
            w_if_valid = 1'b1;
            w_if_instr = i_data;
            w_if_pc    = r_pc;
            w_pc       = pred_next_pc;
            w_deliver  = 1'b1;
          end else if (i_ready) begin
            w_buf_valid  = 1'b1;
            w_buf_instr  = i_data;
            w_buf_pc     = r_pc;
            w_buf_next   = pred_next_pc;
            w_next_state = S_HOLD;
          end else if (!stall) begin
            w_if_valid = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_if_valid   = 1'b1;
            w_if_instr   = r_buf_instr;
            w_if_pc      = r_buf_pc;
            w_pc         = r_buf_next;
            w_buf_valid  = 1'b0;
            w_deliver    = 1'b1;
            w_next_state = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (!stall) w_if_valid = 1'b0;
          if (i_ready) w_next_state = S_FETCH;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_pc             <= RESET_PC;
      r_drain_addr     <= RESET_PC;
      r_buf_valid      <= 1'b0;
      r_buf_instr      <= '0;
      r_buf_pc         <= '0;
      r_buf_next       <= '0;
      r_if_valid       <= 1'b0;
      r_if_instr       <= '0;
      r_if_pc          <= '0;
      r_flush          <= 1'b0;
      r_stat_fetched   <= '0;
      r_stat_redirects <= '0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_pc;
      r_drain_addr <= w_drain_addr;
      r_buf_valid  <= w_buf_valid;
      r_buf_instr  <= w_buf_instr;
      r_buf_pc     <= w_buf_pc;
      r_buf_next   <= w_buf_next;
      r_if_valid   <= w_if_valid;
      r_if_instr   <= w_if_instr;
      r_if_pc      <= w_if_pc;
      r_flush      <= w_redirect_taken;
      if (w_deliver && r_stat_fetched != '1)
        r_stat_fetched <= r_stat_fetched + c_stat_one;
      if (w_redirect_taken && r_stat_redirects != '1)
        r_stat_redirects <= r_stat_redirects + c_stat_one;
    end
  end

  assign i_readM        = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign i_address      = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign pred_pc        = (r_state == S_HOLD) ? r_buf_pc : r_pc;
  assign pred_instr     = (r_state == S_HOLD) ? r_buf_instr : i_data;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;
  assign flush          = r_flush;
  assign stat_fetched   = r_stat_fetched;
  assign stat_redirects = r_stat_redirects;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : directed self-checking bench for fetch_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_readM;
  logic [15:0] i_address;
  logic        i_ready = 1'b0;
  logic [15:0] i_data;
  logic [15:0] pred_pc, pred_instr, pred_next_pc;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        if_valid;
  logic [15:0] if_instr, if_pc;
  logic        flush;
  logic [3:0]  stat_fetched, stat_redirects;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Memory: opcode 0xB is a branch with signed 8-bit offset, everything else falls through
  assign i_data = (i_address == 16'h000F) ? 16'hB003 : {4'h1, i_address[11:0]};
  assign pred_next_pc = (pred_instr[15:12] == 4'hB)
                      ? pred_pc + 16'd1 + {{8{pred_instr[7]}}, pred_instr[7:0]}
                      : pred_pc + 16'd1;

  fetch_sequencer #(.WORD_SIZE(16), .RESET_PC(16'h0000), .STAT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_address(i_address), .i_ready(i_ready), .i_data(i_data),
    .pred_pc(pred_pc), .pred_instr(pred_instr), .pred_next_pc(pred_next_pc),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .stat_fetched(stat_fetched), .stat_redirects(stat_redirects)
  );

  // Reset, release, and return at the first negedge in FETCH
  task automatic reset_start(input logic ready);
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; i_ready = ready;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_to(input logic [15:0] target);
    int cnt = 0;
    while (i_address !== target && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++; if (i_address !== target) begin n_fail++; $display("FAIL run_to_timeout: got %h expected %h", i_address, target); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if (i_readM !== 1'b0) begin n_fail++; $display("FAIL rst_readM: got %b expected 0", i_readM); end
    n_checks++; if (i_address !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", i_address); end
    n_checks++; if ({if_valid, if_instr, if_pc, flush} !== 34'd0) begin n_fail++; $display("FAIL rst_ifid: got %b/%h/%h/%b expected all zero", if_valid, if_instr, if_pc, flush); end
    n_checks++; if ({stat_fetched, stat_redirects} !== 8'h00) begin n_fail++; $display("FAIL rst_stats: got %h/%h expected 0/0", stat_fetched, stat_redirects); end
  endtask

  task automatic test_sequential;
    reset_n = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (i_readM !== 1'b0) begin n_fail++; $display("FAIL seq_idle_readM: got %b expected 0", i_readM); end
    @(negedge clk);
    n_checks++; if (i_readM !== 1'b1 || i_address !== 16'h0000) begin n_fail++; $display("FAIL seq_addr0: got %b/%h expected 1/0000", i_readM, i_address); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_ifvalid0: got %b expected 0", if_valid); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++; if (i_address !== 16'(k)) begin n_fail++; $display("FAIL seq_addr: got %h expected %h", i_address, 16'(k)); end
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'(k-1) || if_instr !== (16'h1000 | 16'(k-1))) begin n_fail++; $display("FAIL seq_ifid: got %b/%h/%h expected 1/%h/%h", if_valid, if_pc, if_instr, 16'(k-1), 16'h1000 | 16'(k-1)); end
    end
    n_checks++; if (stat_fetched !== 4'd3) begin n_fail++; $display("FAIL seq_stat: got %0d expected 3", stat_fetched); end
  endtask

  task automatic test_wait_states;
    reset_start(1'b0);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (i_address !== 16'h0000 || i_readM !== 1'b1) begin n_fail++; $display("FAIL ws_hold_addr: got %b/%h expected 1/0000", i_readM, i_address); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL ws_bubble: got %b expected 0", if_valid); end
      if (k == 2) i_ready = 1'b1;
      @(negedge clk);
    end
    i_ready = 1'b0;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1000) begin n_fail++; $display("FAIL ws_load: got %b/%h/%h expected 1/0000/1000", if_valid, if_pc, if_instr); end
    n_checks++; if (i_address !== 16'h0001) begin n_fail++; $display("FAIL ws_next: got %h expected 0001", i_address); end
  endtask

  task automatic test_stall_hold;
    reset_start(1'b1);
    run_to(16'h000F);
    stall = 1'b1;
    @(negedge clk);
    n_checks++; if (i_readM !== 1'b0) begin n_fail++; $display("FAIL hold_readM: got %b expected 0", i_readM); end
    n_checks++; if (if_pc !== 16'h000E || if_valid !== 1'b1) begin n_fail++; $display("FAIL hold_ifid: got %b/%h expected 1/000E", if_valid, if_pc); end
    n_checks++; if (pred_pc !== 16'h000F || pred_instr !== 16'hB003) begin n_fail++; $display("FAIL hold_pred: got %h/%h expected 000F/B003", pred_pc, pred_instr); end
    n_checks++; if (stat_fetched !== 4'hF) begin n_fail++; $display("FAIL hold_stat_sat: got %h expected F", stat_fetched); end
    @(negedge clk);
    n_checks++; if (i_readM !== 1'b0 || if_pc !== 16'h000E) begin n_fail++; $display("FAIL hold2: got %b/%h expected 0/000E", i_readM, if_pc); end
    stall = 1'b0;
    @(negedge clk);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h000F || if_instr !== 16'hB003) begin n_fail++; $display("FAIL hold_release: got %b/%h/%h expected 1/000F/B003", if_valid, if_pc, if_instr); end
    n_checks++; if (i_readM !== 1'b1 || i_address !== 16'h0013) begin n_fail++; $display("FAIL hold_target: got %b/%h expected 1/0013", i_readM, i_address); end
    n_checks++; if (stat_fetched !== 4'hF) begin n_fail++; $display("FAIL stat_no_wrap: got %h expected F", stat_fetched); end
  endtask

  task automatic test_redirect_drain;
    reset_start(1'b1);
    run_to(16'h0005);
    i_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (i_readM !== 1'b1 || i_address !== 16'h0005) begin n_fail++; $display("FAIL drain_addr1: got %b/%h expected 1/0005", i_readM, i_address); end
    n_checks++; if (flush !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL drain_flush: got %b/%b expected flush 1 valid 0", flush, if_valid); end
    n_checks++; if (stat_redirects !== 4'd1) begin n_fail++; $display("FAIL drain_stat: got %0d expected 1", stat_redirects); end
    @(negedge clk);
    n_checks++; if (i_address !== 16'h0005 || flush !== 1'b0) begin n_fail++; $display("FAIL drain_addr2: got %h/%b expected 0005/0", i_address, flush); end
    i_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (i_address !== 16'h0040 || if_valid !== 1'b0 || stat_fetched !== 4'd5) begin n_fail++; $display("FAIL drain_drop: got %h/%b/%0d expected 0040/0/5", i_address, if_valid, stat_fetched); end
    @(negedge clk);
    i_ready = 1'b0;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0040 || i_address !== 16'h0041) begin n_fail++; $display("FAIL drain_resume: got %b/%h/%h expected 1/0040/0041", if_valid, if_pc, i_address); end
    n_checks++; if (stat_redirects !== 4'd1 || flush !== 1'b0) begin n_fail++; $display("FAIL drain_once: got %0d/%b expected 1/0", stat_redirects, flush); end
  endtask

  task automatic test_redirect_in_hold;
    reset_start(1'b1);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    n_checks++; if (i_readM !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h0000) begin n_fail++; $display("FAIL rh_hold: got %b/%b/%h expected 0/1/0000", i_readM, if_valid, if_pc); end
    redirect = 1'b1; redirect_pc = 16'h0080;
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0; i_ready = 1'b0;
    n_checks++; if (i_readM !== 1'b1 || i_address !== 16'h0080) begin n_fail++; $display("FAIL rh_addr: got %b/%h expected 1/0080", i_readM, i_address); end
    n_checks++; if (if_valid !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL rh_clear: got %b/%b expected valid 0 flush 1", if_valid, flush); end
    n_checks++; if (stat_redirects !== 4'd1 || stat_fetched !== 4'd1) begin n_fail++; $display("FAIL rh_stats: got %0d/%0d expected 1/1", stat_redirects, stat_fetched); end
    @(negedge clk);
    n_checks++; if (flush !== 1'b0 || if_valid !== 1'b0 || i_address !== 16'h0080) begin n_fail++; $display("FAIL rh_after: got %b/%b/%h expected 0/0/0080", flush, if_valid, i_address); end
  endtask

  task automatic test_reset_mid_drain;
    reset_start(1'b0);
    redirect = 1'b1; redirect_pc = 16'h0020;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (i_readM !== 1'b1 || flush !== 1'b1) begin n_fail++; $display("FAIL rmd_pre: got %b/%b expected 1/1", i_readM, flush); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (i_readM !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL rmd_async: got %b/%b expected 0/0", i_readM, flush); end
    n_checks++; if (pred_pc !== 16'h0000 || i_address !== 16'h0000) begin n_fail++; $display("FAIL rmd_pc: got %h/%h expected 0000/0000", pred_pc, i_address); end
    n_checks++; if ({stat_fetched, stat_redirects, if_valid} !== 9'd0) begin n_fail++; $display("FAIL rmd_state: got %h/%h/%b expected 0/0/0", stat_fetched, stat_redirects, if_valid); end
    @(negedge clk);
    i_ready = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (i_readM !== 1'b1 || i_address !== 16'h0000) begin n_fail++; $display("FAIL rmd_restart: got %b/%h expected 1/0000", i_readM, i_address); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_in_hold();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
